// File: rtl/slew_rate_monitor.sv
// Measures the peak sample-to-sample delta of an audio stream over a window of
// WINDOW deltas, and counts how many deltas exceed a fixed slew threshold.
module slew_rate_monitor #(
   parameter int VCC             = 12,
   parameter int SAMPLE_RATE     = 48000,
   parameter int MAX_CHANGE_RATE = 950,
   parameter int WINDOW          = 1024
)(
   input  logic        clk,
   input  logic        I_RST,
   input  logic        audio_clk_en,
   input  logic [15:0] in,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [16:0] peak_delta,
   output logic [15:0] violation_count,
   output logic        violation
);

   // Full scale (1<<14) corresponds to VCC volts; threshold is the largest
   // per-sample step in counts that stays within MAX_CHANGE_RATE.
   localparam longint      THR_L = (longint'(MAX_CHANGE_RATE) <<< 14)
                                   / longint'(VCC) / longint'(SAMPLE_RATE);
   localparam logic [16:0] THR   = 17'(THR_L);
   localparam logic [15:0] WIN   = 16'(WINDOW);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRIME   = 2'd1,
      MEASURE = 2'd2,
      REPORT  = 2'd3
   } state_t;

   state_t      state_r;
   logic [15:0] prev_r;
   logic [15:0] cnt_r;
   logic [16:0] diff_s;
   logic [16:0] mag_s;
   logic [15:0] cnt_next_s;
   logic        over_s;

   // Delta magnitude; 17-bit signed difference so full-scale swings never wrap.
   always_comb begin
      diff_s = {in[15], in} - {prev_r[15], prev_r};
      if (diff_s[16]) begin
         mag_s = 17'd0 - diff_s;
      end else begin
         mag_s = diff_s;
      end
      over_s     = (mag_s > THR);
      cnt_next_s = cnt_r + 16'd1;
   end

   // Measurement sequencer with registered status and result outputs.
   always_ff @(posedge clk) begin
      if (I_RST) begin
         state_r         <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         peak_delta      <= 17'd0;
         violation_count <= 16'd0;
         violation       <= 1'b0;
         prev_r          <= 16'd0;
         cnt_r           <= 16'd0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r         <= PRIME;
                  busy            <= 1'b1;
                  peak_delta      <= 17'd0;
                  violation_count <= 16'd0;
                  violation       <= 1'b0;
                  cnt_r           <= 16'd0;
               end
            end
            PRIME: begin
               if (audio_clk_en) begin
                  prev_r  <= in;
                  state_r <= MEASURE;
               end
            end
            MEASURE: begin
               if (audio_clk_en) begin
                  prev_r    <= in;
                  cnt_r     <= cnt_next_s;
                  violation <= over_s;
                  if (mag_s > peak_delta) begin
                     peak_delta <= mag_s;
                  end
                  if (over_s && (violation_count != 16'hFFFF)) begin
                     violation_count <= violation_count + 16'd1;
                  end
                  if (cnt_next_s == WIN) begin
                     state_r <= REPORT;
                     done    <= 1'b1;
                  end
               end
            end
            REPORT: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slew_rate_monitor.sv
// Self-checking bench: three monitors (WINDOW 4, 1, 65535) share one sample stream.
module tb_slew_rate_monitor;

   localparam longint THR = (longint'(950) <<< 14) / 12 / 48000;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] din;
   logic [2:0]  start_v;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [2:0]  viol_v;
   logic [16:0] peak_v [3];
   logic [15:0] cnt_v  [3];

   int     checks = 0;
   int     errors = 0;
   int     samp_q[$];
   longint exp_peak;
   longint exp_cnt;
   bit     exp_viol;

   always #5 clk = ~clk;

   slew_rate_monitor #(.WINDOW(4)) u_w4 (
      .clk(clk), .I_RST(rst), .audio_clk_en(en), .in(din), .start(start_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .peak_delta(peak_v[0]),
      .violation_count(cnt_v[0]), .violation(viol_v[0]));

   slew_rate_monitor #(.WINDOW(1)) u_w1 (
      .clk(clk), .I_RST(rst), .audio_clk_en(en), .in(din), .start(start_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .peak_delta(peak_v[1]),
      .violation_count(cnt_v[1]), .violation(viol_v[1]));

   slew_rate_monitor #(.WINDOW(65535)) u_wbig (
      .clk(clk), .I_RST(rst), .audio_clk_en(en), .in(din), .start(start_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .peak_delta(peak_v[2]),
      .violation_count(cnt_v[2]), .violation(viol_v[2]));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: results from the whole sample list (first entry is the prime sample).
   task automatic model;
      longint a;
      longint c;
      exp_peak = 0;
      c        = 0;
      exp_viol = 1'b0;
      for (int i = 1; i < samp_q.size(); i++) begin
         a = longint'(samp_q[i]) - longint'(samp_q[i-1]);
         if (a < 0) a = -a;
         if (a > exp_peak) exp_peak = a;
         if (a > THR) c++;
         exp_viol = (a > THR);
      end
      exp_cnt = (c > 65535) ? 65535 : c;
   endtask

   task automatic chk_results(input string pfx, input int w);
      chk({pfx, "_peak"}, 32'(peak_v[w]), 32'(exp_peak));
      chk({pfx, "_count"}, 32'(cnt_v[w]), 32'(exp_cnt));
      chk({pfx, "_viol"}, 32'(viol_v[w]), 32'(exp_viol));
   endtask

   task automatic chk_zero(input string pfx, input int w);
      chk({pfx, "_busy"}, 32'(busy_v[w]), 32'd0);
      chk({pfx, "_done"}, 32'(done_v[w]), 32'd0);
      chk({pfx, "_peak"}, 32'(peak_v[w]), 32'd0);
      chk({pfx, "_count"}, 32'(cnt_v[w]), 32'd0);
      chk({pfx, "_viol"}, 32'(viol_v[w]), 32'd0);
   endtask

   task automatic run_window(input int w, input bit coincide, input bit gaps, input bit busy_starts);
      int n;
      model();
      start_v[w] = 1'b1;
      if (coincide) begin
         en  = 1'b1;
         din = 16'h4E20;
      end
      tick;
      start_v = 3'b000;
      en      = 1'b0;
      chk("start_busy", 32'(busy_v[w]), 32'd1);
      chk("start_clr_peak", 32'(peak_v[w]), 32'd0);
      chk("start_clr_count", 32'(cnt_v[w]), 32'd0);
      chk("start_clr_viol", 32'(viol_v[w]), 32'd0);
      for (int i = 0; i < samp_q.size(); i++) begin
         if (gaps) begin
            n = int'($urandom_range(0, 2));
            repeat (n) begin
               if (busy_starts) start_v[w] = 1'($urandom_range(0, 1));
               tick;
               start_v = 3'b000;
            end
         end
         if (busy_starts) start_v[w] = 1'($urandom_range(0, 1));
         en  = 1'b1;
         din = 16'(samp_q[i]);
         tick;
         en      = 1'b0;
         start_v = 3'b000;
         if (i < samp_q.size() - 1) begin
            chk("done_early", 32'(done_v[w]), 32'd0);
         end else begin
            chk("done_pulse", 32'(done_v[w]), 32'd1);
            chk("report_busy", 32'(busy_v[w]), 32'd1);
            chk_results("report", w);
         end
      end
      tick;
      chk("done_clear", 32'(done_v[w]), 32'd0);
      chk("idle_busy", 32'(busy_v[w]), 32'd0);
      chk_results("idle", w);
   endtask

   task automatic hold_check(input int w);
      repeat (4) begin
         en  = 1'b1;
         din = 16'($urandom);
         tick;
         en = 1'b0;
         chk("hold_busy", 32'(busy_v[w]), 32'd0);
         chk("hold_done", 32'(done_v[w]), 32'd0);
         chk_results("hold", w);
      end
   endtask

   task automatic gen(input int n, input bit full);
      int s;
      samp_q.delete();
      s = int'($urandom_range(0, 65535)) - 32768;
      for (int i = 0; i < n; i++) begin
         if (full) begin
            s = int'($urandom_range(0, 65535)) - 32768;
         end else begin
            s = s + int'($urandom_range(0, 60)) - 30;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
         end
         samp_q.push_back(s);
      end
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b1;
      din     = 16'h1234;
      start_v = 3'b111;
      tick;
      tick;
      for (int w = 0; w < 3; w++) chk_zero("reset", w);
      rst     = 1'b0;
      en      = 1'b0;
      start_v = 3'b000;
      tick;
      chk("post_reset_busy", 32'(busy_v[0]), 32'd0);

      samp_q = '{0, 27, 54, 81, 108};
      run_window(0, 1'b0, 1'b0, 1'b0);
      hold_check(0);

      samp_q = '{0, 0, 100, 100, -100};
      run_window(0, 1'b0, 1'b1, 1'b1);
      hold_check(0);

      samp_q = '{0, 27, 0, 28, 0};
      run_window(0, 1'b0, 1'b1, 1'b0);

      samp_q = '{-32768, 32767};
      run_window(1, 1'b0, 1'b0, 1'b0);
      samp_q = '{32767, -32768};
      run_window(1, 1'b0, 1'b1, 1'b1);

      samp_q = '{0, 10, 20, 30, 40};
      run_window(0, 1'b1, 1'b0, 1'b0);

      start_v[0] = 1'b1;
      tick;
      start_v = 3'b000;
      en = 1'b1;
      din = 16'd0;   tick;
      din = 16'd500; tick;
      din = 16'd0;   tick;
      en = 1'b0;
      chk("pre_reset_peak", 32'(peak_v[0]), 32'd500);
      chk("pre_reset_count", 32'(cnt_v[0]), 32'd2);
      rst        = 1'b1;
      start_v[0] = 1'b1;
      en         = 1'b1;
      din        = 16'd7;
      tick;
      rst     = 1'b0;
      start_v = 3'b000;
      en      = 1'b0;
      chk_zero("mid_reset", 0);
      repeat (8) begin
         en  = 1'b1;
         din = 16'($urandom);
         tick;
         en = 1'b0;
         chk("abandon_done", 32'(done_v[0]), 32'd0);
         chk("abandon_busy", 32'(busy_v[0]), 32'd0);
      end
      samp_q = '{5, 50, 40, 100, 101};
      run_window(0, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 16; k++) begin
         int w;
         w = int'($urandom_range(0, 1));
         gen((w == 0) ? 5 : 2, 1'($urandom_range(0, 1)));
         run_window(w, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
         if (k % 4 == 0) hold_check(w);
      end

      samp_q.delete();
      for (int i = 0; i < 65536; i++) samp_q.push_back((i % 2 == 0) ? 1000 : -1000);
      run_window(2, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
